// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the 24-bit CPU.
// It holds the CPU in reset for RST_HOLD edges after board reset release.
// It gates the CPU clock enable for bounded runs, free runs, single steps and halts.
// It keeps a saturating count of enabled CPU cycles since the last Start.
// Optional feature macro: RUN_CTRL_BREAK_EN adds a PC breakpoint (Pc, BreakPc, BreakEn, BreakHit).
module cpu_run_ctrl #(
  parameter int CYCLE_W  = 16,
  parameter int RST_HOLD = 4
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Step,
  input  logic               Halt,
  input  logic [CYCLE_W-1:0] Cycles,
  output logic               CpuEn,
  output logic               CpuReset_n,
  output logic               Running,
  output logic               Done,
  output logic [CYCLE_W-1:0] CycleCount
`ifdef RUN_CTRL_BREAK_EN
  ,
  input  logic [23:0]        Pc,
  input  logic [23:0]        BreakPc,
  input  logic               BreakEn,
  output logic               BreakHit
`endif
);

  // The hold counter must be able to hold the value RST_HOLD itself.
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [CYCLE_W-1:0]   len_q, len_d;
  logic [CYCLE_W-1:0]   cnt_q, cnt_d;
  logic                 en_q, en_d;
  logic                 rstn_q, rstn_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;
  logic [CYCLE_W:0]     cnt_plus1;
  logic                 len_end;
`ifdef RUN_CTRL_BREAK_EN
  logic                 brk_q, brk_d;
  logic                 brk_match;

  assign brk_match = BreakEn && (Pc == BreakPc);
`endif

  // One extra bit so a saturated count can never alias onto a nonzero length.
  assign cnt_plus1 = {1'b0, cnt_q} + {{CYCLE_W{1'b0}}, 1'b1};
  assign len_end   = (len_q != '0) && (cnt_plus1 == {1'b0, len_q});

  // Next-state and next-output decode; every output is re-derived from the next state so it is a plain flop.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef RUN_CTRL_BREAK_EN
    brk_d   = brk_q;
`endif

    // Every enabled CPU edge counts, saturating at all-ones.
    if (en_q && !(&cnt_q)) begin
      cnt_d = cnt_plus1[CYCLE_W-1:0];
    end

    case (state_q)
      S_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE, S_DONE: begin
        if (Start) begin
          cnt_d   = '0;
          len_d   = Cycles;
          state_d = S_RUN;
`ifdef RUN_CTRL_BREAK_EN
          brk_d   = 1'b0;
`endif
        end else if (Step) begin
          state_d = S_STEP;
`ifdef RUN_CTRL_BREAK_EN
          brk_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (Halt) begin
          state_d = S_DONE;
        end
`ifdef RUN_CTRL_BREAK_EN
        else if (brk_match) begin
          state_d = S_DONE;
          brk_d   = 1'b1;
        end
`endif
        else if (len_end) begin
          state_d = S_DONE;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase

    en_d   = (state_d == S_RUN) || (state_d == S_STEP);
    run_d  = (state_d == S_RUN) || (state_d == S_STEP);
    done_d = (state_d == S_DONE);
    rstn_d = (state_d != S_HOLD);
  end

  // State and output registers; board reset forces everything back immediately.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_HOLD;
      hold_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rstn_q  <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef RUN_CTRL_BREAK_EN
      brk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rstn_q  <= rstn_d;
      run_q   <= run_d;
      done_q  <= done_d;
`ifdef RUN_CTRL_BREAK_EN
      brk_q   <= brk_d;
`endif
    end
  end

  assign CpuEn      = en_q;
  assign CpuReset_n = rstn_q;
  assign Running    = run_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;
`ifdef RUN_CTRL_BREAK_EN
  assign BreakHit   = brk_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed stimulus pushes expected output vectors
// into a scoreboard; a negedge monitor compares them when their cycle arrives.
// Covers RUN_CTRL_BREAK_EN when that macro is defined.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, step, halt;
  logic [15:0] cycles;
  logic        en, rstn, run, done;
  logic [15:0] cnt;

  logic        start4, step4, halt4;
  logic [3:0]  cycles4;
  logic        en4, rstn4, run4, done4;
  logic [3:0]  cnt4;

`ifdef RUN_CTRL_BREAK_EN
  logic [23:0] pc, break_pc;
  logic        break_en, break_hit, break_hit4;
`endif

  cpu_run_ctrl #(.CYCLE_W(16), .RST_HOLD(4)) dut (
    .Clock(clk), .Reset_n(rst_n), .Start(start), .Step(step), .Halt(halt),
    .Cycles(cycles), .CpuEn(en), .CpuReset_n(rstn), .Running(run), .Done(done),
    .CycleCount(cnt)
`ifdef RUN_CTRL_BREAK_EN
    , .Pc(pc), .BreakPc(break_pc), .BreakEn(break_en), .BreakHit(break_hit)
`endif
  );

  cpu_run_ctrl #(.CYCLE_W(4), .RST_HOLD(4)) dut4 (
    .Clock(clk), .Reset_n(rst_n), .Start(start4), .Step(step4), .Halt(halt4),
    .Cycles(cycles4), .CpuEn(en4), .CpuReset_n(rstn4), .Running(run4), .Done(done4),
    .CycleCount(cnt4)
`ifdef RUN_CTRL_BREAK_EN
    , .Pc(24'h0), .BreakPc(24'h0), .BreakEn(1'b0), .BreakHit(break_hit4)
`endif
  );

  typedef struct {
    int          cyc;
    string       name;
    bit          sel;
    logic [20:0] vec;   // {en, rstn, run, done, brk, cnt[15:0]}
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue the expected output vector d cycles after the current edge.
  task automatic expect_at(input int d, input string nm, input bit sel,
                           input logic e, input logic r, input logic ru,
                           input logic dn, input logic [15:0] c, input logic b);
    exp_t x;
    x.cyc  = cyc + d;
    x.name = nm;
    x.sel  = sel;
    x.vec  = {e, r, ru, dn, b, c};
    sb.push_back(x);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Record the outcome of an immediate check.
  task automatic report(input string nm, input bit ok);
    n_checks++;
    if (ok) begin
      n_pass++;
      $display("ok   %-18s cyc=%0d en=%b rstn=%b run=%b done=%b cnt=%0d cnt4=%0d",
               nm, cyc, en, rstn, run, done, cnt, cnt4);
    end else begin
      $display("FAIL %s cyc=%0d en=%b rstn=%b run=%b done=%b cnt=%0d en4=%b done4=%b cnt4=%0d",
               nm, cyc, en, rstn, run, done, cnt, en4, done4, cnt4);
    end
  endtask

  function automatic logic [20:0] actual(input bit sel);
    logic b, b4;
`ifdef RUN_CTRL_BREAK_EN
    b  = break_hit;
    b4 = break_hit4;
`else
    b  = 1'b0;
    b4 = 1'b0;
`endif
    if (sel) return {en4, rstn4, run4, done4, b4, 12'h000, cnt4};
    return {en, rstn, run, done, b, cnt};
  endfunction

  // Monitor: compare every scoreboard entry due at this cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [20:0] a;
        a = actual(sb[i].sel);
        n_checks++;
        if (a == sb[i].vec) begin
          n_pass++;
          $display("ok   %-18s cyc=%0d en=%b rstn=%b run=%b done=%b brk=%b cnt=%0d",
                   sb[i].name, cyc, a[20], a[19], a[18], a[17], a[16], a[15:0]);
        end else begin
          $display("FAIL %s cyc=%0d got en=%b rstn=%b run=%b done=%b brk=%b cnt=%0d expected en=%b rstn=%b run=%b done=%b brk=%b cnt=%0d",
                   sb[i].name, cyc, a[20], a[19], a[18], a[17], a[16], a[15:0],
                   sb[i].vec[20], sb[i].vec[19], sb[i].vec[18], sb[i].vec[17],
                   sb[i].vec[16], sb[i].vec[15:0]);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; step = 1'b0; halt = 1'b0; cycles = 16'd0;
    start4 = 1'b0; step4 = 1'b0; halt4 = 1'b0; cycles4 = 4'd0;
`ifdef RUN_CTRL_BREAK_EN
    pc = 24'd0; break_pc = 24'h000003; break_en = 1'b0;
`endif

    // Reset values on both instances.
    expect_at(1, "reset_main", 0, 0, 0, 0, 0, 16'd0, 0);
    expect_at(1, "reset_w4",   1, 0, 0, 0, 0, 16'd0, 0);
    adv(2);

    // Release reset; Start held during HOLD must be ignored; Halt in IDLE ignored.
    rst_n = 1'b1; start = 1'b1; cycles = 16'd5;
    expect_at(1, "hold_edge1",     0, 0, 0, 0, 0, 16'd0, 0);
    expect_at(3, "hold_edge3",     0, 0, 0, 0, 0, 16'd0, 0);
    expect_at(4, "hold_release",   0, 0, 1, 0, 0, 16'd0, 0);
    expect_at(4, "hold_release_w4",1, 0, 1, 0, 0, 16'd0, 0);
    expect_at(5, "start_in_hold",  0, 0, 1, 0, 0, 16'd0, 0);
    adv(4);
    report("imm_hold_release", (rstn == 1'b1) && (en == 1'b0));
    start = 1'b0; halt = 1'b1;
    adv(1);
    halt = 1'b0;

    // Bounded run of 30 cycles.
    start = 1'b1; cycles = 16'd30;
    expect_at(1,  "run30_start", 0, 1, 1, 1, 0, 16'd0, 0);
    expect_at(2,  "run30_cnt1",  0, 1, 1, 1, 0, 16'd1, 0);
    expect_at(30, "run30_last",  0, 1, 1, 1, 0, 16'd29, 0);
    expect_at(31, "run30_done",  0, 0, 1, 0, 1, 16'd30, 0);
    expect_at(32, "run30_stay",  0, 0, 1, 0, 1, 16'd30, 0);
    adv(1);
    start = 1'b0;
    adv(31);
    report("imm_run30_final", (cnt == 16'd30) && (done == 1'b1) && (run == 1'b0) && (en == 1'b0));

    // Three single steps from DONE, spaced 3 cycles apart.
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      expect_at(1, $sformatf("step%0d_on", i),  0, 1, 1, 1, 0, 16'(30 + i), 0);
      expect_at(2, $sformatf("step%0d_off", i), 0, 0, 1, 0, 0, 16'(31 + i), 0);
      adv(1);
      step = 1'b0;
      adv(2);
    end
    report("imm_steps_cnt33", (cnt == 16'd33) && (en == 1'b0));

    // Start beats Step; free run halted when count reaches 10.
    start = 1'b1; step = 1'b1; cycles = 16'd0;
    expect_at(1, "start_beats_step", 0, 1, 1, 1, 0, 16'd0, 0);
    adv(1);
    start = 1'b0; step = 1'b0;
    adv(10);
    expect_at(0, "free_cnt10", 0, 1, 1, 1, 0, 16'd10, 0);
    halt = 1'b1;
    expect_at(1, "halt_stop",  0, 0, 1, 0, 1, 16'd11, 0);
    expect_at(2, "halt_stays", 0, 0, 1, 0, 1, 16'd11, 0);
    adv(1);
    halt = 1'b0;
    adv(2);
    report("imm_halt_cnt11", (cnt == 16'd11) && (done == 1'b1));

    // Shortest bounded run.
    start = 1'b1; cycles = 16'd1;
    expect_at(1, "run1_start", 0, 1, 1, 1, 0, 16'd0, 0);
    expect_at(2, "run1_done",  0, 0, 1, 0, 1, 16'd1, 0);
    adv(1);
    start = 1'b0;
    adv(2);

    // 4-bit counter saturates during a free run and the run keeps going.
    start4 = 1'b1; cycles4 = 4'd0;
    expect_at(1,  "w4_start", 1, 1, 1, 1, 0, 16'd0, 0);
    expect_at(16, "w4_cnt15", 1, 1, 1, 1, 0, 16'd15, 0);
    expect_at(17, "w4_sat",   1, 1, 1, 1, 0, 16'd15, 0);
    expect_at(21, "w4_edge20",1, 1, 1, 1, 0, 16'd15, 0);
    adv(1);
    start4 = 1'b0;
    adv(20);
    halt4 = 1'b1;
    expect_at(1, "w4_halt", 1, 0, 1, 0, 1, 16'd15, 0);
    adv(1);
    halt4 = 1'b0;
    adv(1);
    report("imm_w4_saturated", (cnt4 == 4'd15) && (done4 == 1'b1) && (en4 == 1'b0));

`ifdef RUN_CTRL_BREAK_EN
    // Breakpoint at Pc == 3 stops a long bounded run.
    break_en = 1'b1; start = 1'b1; cycles = 16'd100;
    expect_at(1, "brk_start", 0, 1, 1, 1, 0, 16'd0, 0);
    adv(1);
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      pc = 24'(j);
      adv(1);
    end
    expect_at(0, "brk_stop", 0, 0, 1, 0, 1, 16'd4, 1);
    break_en = 1'b0;
    adv(2);
`endif

    // Board reset mid-run clears outputs before the next edge, then HOLD reruns.
    start = 1'b1; cycles = 16'd100;
    expect_at(1, "rst_run_start", 0, 1, 1, 1, 0, 16'd0, 0);
    expect_at(5, "rst_run_cnt4",  0, 1, 1, 1, 0, 16'd4, 0);
    adv(1);
    start = 1'b0;
    adv(5);
    rst_n = 1'b0;
    expect_at(0, "async_reset",    0, 0, 0, 0, 0, 16'd0, 0);
    expect_at(0, "async_reset_w4", 1, 0, 0, 0, 0, 16'd0, 0);
    #1;
    report("imm_async_reset", (en == 1'b0) && (rstn == 1'b0) && (cnt == 16'd0));
    adv(1);
    rst_n = 1'b1;
    expect_at(3, "rehold_edge3",   0, 0, 0, 0, 0, 16'd0, 0);
    expect_at(4, "rehold_release", 0, 0, 1, 0, 0, 16'd0, 0);
    adv(6);

    // Any expectation never reached by the monitor is a failure.
    foreach (sb[i]) begin
      n_checks++;
      $display("FAIL %s not checked (due cyc=%0d, now %0d)", sb[i].name, sb[i].cyc, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
